// File: rtl/iq_impair_if.sv
// Sample/coefficient bus for the IQ impairment block.
// The master drives samples and coefficients; the slave returns the impaired samples and status.
interface iq_impair_if;
  logic       en;
  logic       in_valid;
  logic [3:0] Ii;
  logic [3:0] Qi;
  logic       load;
  logic [7:0] gain_in;
  logic [7:0] phase_in;
  logic [3:0] dc_i_in;
  logic [3:0] dc_q_in;
  logic [3:0] Ix;
  logic [3:0] Qx;
  logic       out_valid;
  logic [7:0] sat_cnt;
  logic       coeff_ack;

  modport master (
    output en, in_valid, Ii, Qi, load, gain_in, phase_in, dc_i_in, dc_q_in,
    input  Ix, Qx, out_valid, sat_cnt, coeff_ack
  );

  modport slave (
    input  en, in_valid, Ii, Qi, load, gain_in, phase_in, dc_i_in, dc_q_in,
    output Ix, Qx, out_valid, sat_cnt, coeff_ack
  );
endinterface

// File: rtl/iq_impair.sv
// Two-stage IQ impairment model: gain/phase imbalance on Q, then DC offset on both rails,
// saturating arithmetic and offset-binary (ADC style) output with a sticky clip counter.
module iq_impair (
  input  logic          clk,
  input  logic          RESETn,
  iq_impair_if.slave    bus
);

  localparam int unsigned SW    = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned PW    = 14;
  localparam int unsigned SHIFT = 6;
  localparam int unsigned CNTW  = 8;
  localparam int          RND   = 32;

  localparam logic signed [PW-1:0]   SMAX    = PW'(7);
  localparam logic signed [PW-1:0]   SMIN    = PW'(-8);
  localparam logic        [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // Clamp a wide signed value to the 4-bit sample range
  function automatic logic signed [SW-1:0] sat_s(input logic signed [PW-1:0] x);
    if (x > SMAX)      sat_s = SW'(SMAX);
    else if (x < SMIN) sat_s = SW'(SMIN);
    else               sat_s = SW'(x);
  endfunction

  function automatic logic ovf_s(input logic signed [PW-1:0] x);
    ovf_s = (x > SMAX) || (x < SMIN);
  endfunction

  // Active coefficient set
  logic signed [CW-1:0] r_gain;
  logic signed [CW-1:0] r_phase;
  logic signed [SW-1:0] r_dc_i;
  logic signed [SW-1:0] r_dc_q;

  // Stage-1 pipeline registers (dc travels with the sample so each sample sees one coefficient set)
  logic                 r_v1;
  logic signed [SW-1:0] r_im;
  logic signed [SW-1:0] r_qm;
  logic                 r_sat1;
  logic signed [SW-1:0] r_dc_i_s1;
  logic signed [SW-1:0] r_dc_q_s1;

  // Output registers
  logic            r_out_valid;
  logic [SW-1:0]   r_ix;
  logic [SW-1:0]   r_qx;
  logic [CNTW-1:0] r_sat_cnt;
  logic            r_coeff_ack;

  logic                 w_accept;
  logic signed [SW-1:0] w_ii;
  logic signed [SW-1:0] w_qi;
  logic signed [PW-1:0] w_acc;
  logic signed [PW-1:0] w_qm_full;
  logic signed [SW-1:0] w_qm;
  logic                 w_sat1;
  logic signed [PW-1:0] w_io_full;
  logic signed [PW-1:0] w_qo_full;
  logic signed [SW-1:0] w_io;
  logic signed [SW-1:0] w_qo;
  logic                 w_sat2;
  logic                 w_count;

  assign w_accept = bus.en & bus.in_valid;
  assign w_ii     = signed'(bus.Ii);
  assign w_qi     = signed'(bus.Qi);

  // Stage-1 arithmetic: rounded Q correction, arithmetic shift gives floor semantics
  always_comb begin
    w_acc     = PW'(r_gain) * PW'(w_qi) + PW'(r_phase) * PW'(w_ii) + PW'(RND);
    w_qm_full = PW'(w_qi) + (w_acc >>> SHIFT);
    w_qm      = sat_s(w_qm_full);
    w_sat1    = ovf_s(w_qm_full);
  end

  // Stage-2 arithmetic: DC offset add with saturation
  always_comb begin
    w_io_full = PW'(r_im) + PW'(r_dc_i_s1);
    w_qo_full = PW'(r_qm) + PW'(r_dc_q_s1);
    w_io      = sat_s(w_io_full);
    w_qo      = sat_s(w_qo_full);
    w_sat2    = ovf_s(w_io_full) | ovf_s(w_qo_full);
    w_count   = r_v1 & (r_sat1 | w_sat2);
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_gain  <= '0;
      r_phase <= '0;
      r_dc_i  <= '0;
      r_dc_q  <= '0;
    end else if (bus.load) begin
      r_gain  <= signed'(bus.gain_in);
      r_phase <= signed'(bus.phase_in);
      r_dc_i  <= signed'(bus.dc_i_in);
      r_dc_q  <= signed'(bus.dc_q_in);
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_v1      <= 1'b0;
      r_im      <= '0;
      r_qm      <= '0;
      r_sat1    <= 1'b0;
      r_dc_i_s1 <= '0;
      r_dc_q_s1 <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_im      <= w_ii;
        r_qm      <= w_qm;
        r_sat1    <= w_sat1;
        r_dc_i_s1 <= r_dc_i;
        r_dc_q_s1 <= r_dc_q;
      end
    end
  end

  // Offset-binary conversion is an MSB flip of the two's-complement result
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_out_valid <= 1'b0;
      r_ix        <= SW'(8);
      r_qx        <= SW'(8);
    end else begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_ix <= {~w_io[SW-1], w_io[SW-2:0]};
        r_qx <= {~w_qo[SW-1], w_qo[SW-2:0]};
      end
    end
  end

  // Clip counter: load clears with priority over a coincident count
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_sat_cnt   <= '0;
      r_coeff_ack <= 1'b0;
    end else begin
      r_coeff_ack <= bus.load;
      if (bus.load)
        r_sat_cnt <= '0;
      else if (w_count && (r_sat_cnt != CNT_MAX))
        r_sat_cnt <= r_sat_cnt + CNTW'(1);
    end
  end

  assign bus.Ix        = r_ix;
  assign bus.Qx        = r_qx;
  assign bus.out_valid = r_out_valid;
  assign bus.sat_cnt   = r_sat_cnt;
  assign bus.coeff_ack = r_coeff_ack;

endmodule

// File: tb/tb_iq_impair.sv
// Directed bench for iq_impair: a vector table of single samples plus multi-cycle sequences
// for coefficient switching, counter saturation/clear, reset mid-stream and enable drop.
`timescale 1ns/1ps
module tb_iq_impair;

  logic clk;
  logic RESETn;
  iq_impair_if bus();

  iq_impair u_dut (
    .clk    (clk),
    .RESETn (RESETn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #31.25 clk = ~clk;

  int n_vec;
  int n_err;

  typedef struct {
    logic       do_load;
    logic [7:0] g;
    logic [7:0] p;
    logic [3:0] di;
    logic [3:0] dq;
    logic [3:0] ii;
    logic [3:0] qi;
    logic [3:0] ex;
    logic [3:0] eq;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_load(input logic [7:0] g, input logic [7:0] p,
                         input logic [3:0] di, input logic [3:0] dq);
    bus.gain_in  = g;
    bus.phase_in = p;
    bus.dc_i_in  = di;
    bus.dc_q_in  = dq;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.do_load) do_load(v.g, v.p, v.di, v.dq);
    bus.Ii       = v.ii;
    bus.Qi       = v.qi;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_ov"},  32'(bus.out_valid), 32'd1);
    chk({tag, "_ix"},  32'(bus.Ix), 32'(v.ex));
    chk({tag, "_qx"},  32'(bus.Qx), 32'(v.eq));
    chk({tag, "_cnt"}, 32'(bus.sat_cnt), 32'(v.ecnt));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    n_vec = 0;
    n_err = 0;

    // do_load, gain, phase, dc_i, dc_q, Ii, Qi, exp Ix, exp Qx, exp sat_cnt
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 4'h3, 4'hE, 4'hB, 4'h6, 8'd0};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 4'h8, 4'h7, 4'h0, 4'hF, 8'd0};
    vecs[2]  = '{1'b1, 8'h20, 8'h00, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'hE, 8'd0};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h7, 4'h8, 4'hF, 8'd1};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 8'd2};
    vecs[5]  = '{1'b1, 8'h00, 8'hF0, 4'hF, 4'h0, 4'h4, 4'h0, 4'hB, 4'h7, 8'd0};
    vecs[6]  = '{1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'hA, 8'd1};
    vecs[7]  = '{1'b1, 8'h00, 8'h00, 4'h7, 4'h8, 4'h7, 4'hF, 4'hF, 4'h0, 8'd1};
    vecs[8]  = '{1'b1, 8'hC0, 8'h00, 4'h0, 4'h0, 4'h1, 4'h5, 4'h9, 4'h8, 8'd0};
    vecs[9]  = '{1'b1, 8'h10, 8'h10, 4'h0, 4'h0, 4'h2, 4'h3, 4'hA, 4'hC, 8'd0};
    vecs[10] = '{1'b1, 8'h3F, 8'h00, 4'h0, 4'h0, 4'h0, 4'h1, 4'h8, 4'hA, 8'd0};
    vecs[11] = '{1'b1, 8'h00, 8'h00, 4'h3, 4'h2, 4'hD, 4'hE, 4'h8, 4'h8, 8'd0};

    bus.en       = 1'b1;
    bus.in_valid = 1'b0;
    bus.Ii       = '0;
    bus.Qi       = '0;
    bus.load     = 1'b0;
    bus.gain_in  = '0;
    bus.phase_in = '0;
    bus.dc_i_in  = '0;
    bus.dc_q_in  = '0;
    RESETn       = 1'b1;
    #1 RESETn    = 1'b0;
    #5;
    chk("rst_ix",  32'(bus.Ix), 32'h8);
    chk("rst_qx",  32'(bus.Qx), 32'h8);
    chk("rst_ov",  32'(bus.out_valid), 32'd0);
    chk("rst_cnt", 32'(bus.sat_cnt), 32'd0);
    chk("rst_ack", 32'(bus.coeff_ack), 32'd0);
    repeat (3) @(negedge clk);
    RESETn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) apply_vec(i, vecs[i]);

    // Coefficient switch while streaming Qi=4 from identity
    do_load(8'h00, 8'h00, 4'h0, 4'h0);
    bus.Ii = 4'h0;
    bus.Qi = 4'h4;
    bus.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.gain_in = 8'h20;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("sw_ack1", 32'(bus.coeff_ack), 32'd1);
    chk("sw_pre",  32'(bus.Qx), 32'hC);
    @(negedge clk);
    chk("sw_ack0", 32'(bus.coeff_ack), 32'd0);
    chk("sw_old",  32'(bus.Qx), 32'hC);
    @(negedge clk);
    chk("sw_new",  32'(bus.Qx), 32'hE);
    chk("sw_cnt",  32'(bus.sat_cnt), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Load held for three cycles
    bus.load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_ack%0d", i), 32'(bus.coeff_ack), 32'd1);
    end
    bus.load = 1'b0;
    @(negedge clk);
    chk("hold_ack_end", 32'(bus.coeff_ack), 32'd0);

    // Saturation counter sticks at 255, then load clears it against a clipping output
    do_load(8'h3F, 8'h00, 4'h0, 4'h0);
    bus.Ii = 4'h0;
    bus.Qi = 4'h7;
    bus.in_valid = 1'b1;
    repeat (300) @(negedge clk);
    chk("cnt_max", 32'(bus.sat_cnt), 32'd255);
    @(negedge clk);
    chk("cnt_hold", 32'(bus.sat_cnt), 32'd255);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("cnt_clear", 32'(bus.sat_cnt), 32'd0);
    @(negedge clk);
    chk("cnt_after", 32'(bus.sat_cnt), 32'd1);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-stream with a sample in stage 1
    do_load(8'h20, 8'h00, 4'h1, 4'h0);
    bus.Ii = 4'h3;
    bus.Qi = 4'hE;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.Ii = 4'h5;
    bus.Qi = 4'h0;
    @(negedge clk);
    chk("pre_rst_ix", 32'(bus.Ix), 32'hC);
    chk("pre_rst_qx", 32'(bus.Qx), 32'h5);
    #5 RESETn = 1'b0;
    #1;
    bus.in_valid = 1'b0;
    chk("mid_rst_ix", 32'(bus.Ix), 32'h8);
    chk("mid_rst_qx", 32'(bus.Qx), 32'h8);
    chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    RESETn = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("post_rst_ov", 32'(seen), 32'd0);
    apply_vec(100, vecs[0]);

    // Enable drop with a sample in stage 1
    bus.Ii = 4'h0;
    bus.Qi = 4'h1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("en_drop_pulses", 32'(seen), 32'd1);
    chk("en_drop_qx", 32'(bus.Qx), 32'h9);
    bus.load = 1'b1;
    bus.gain_in = 8'h00;
    @(negedge clk);
    bus.load = 1'b0;
    chk("en_off_ack", 32'(bus.coeff_ack), 32'd1);
    bus.in_valid = 1'b0;
    bus.en = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
